// File: rtl/fifo_row_loader_pkg.sv
// Shared types and helpers for the preload row loader.
// Optional stall counter is enabled by FIFO_ROW_LOADER_STALL_CNT_EN (see top).
package fifo_row_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        LOAD,
        STREAM,
        DONE
    } loader_state_t;

    // Cycles needed to push a full row through a DEPTH-stage delay FIFO.
    function automatic int stream_len(input int depth);
        return 2 * depth - 1;
    endfunction

endpackage

// File: rtl/fifo_row_loader_row_assembler.sv
// Assembles one DEPTH-wide row from a serial element stream.
// row_full flags that the beat being accepted this cycle completes the row.
module row_assembler
    import fifo_row_loader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   accept,
    input  logic                   clear,
    input  logic signed [BITS-1:0] data,
    output logic signed [BITS-1:0] row_d [DEPTH-1:0],
    output logic                   row_full
);

    localparam int            CW       = $clog2(DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(DEPTH - 1);

    logic [CW-1:0] col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            col <= '0;
        else if (clear)
            col <= '0;
        else if (accept)
            col <= (col == COL_LAST) ? '0 : col + 1'b1;
    end

    assign row_full = accept && (col == COL_LAST);

    // One register per element; only the addressed slot captures a beat.
    for (genvar i = 0; i < DEPTH; i++) begin : g_elem
        localparam logic [CW-1:0] IDX = CW'(i);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                row_d[i] <= '0;
            else if (accept && (col == IDX))
                row_d[i] <= data;
        end
    end

endmodule

// File: rtl/fifo_row_loader.sv
// Feeds ROWS preload delay FIFOs: assembles rows, strobes them in, then drains.
// Define FIFO_ROW_LOADER_STALL_CNT_EN to count idle FILL cycles on stall_cnt.
module fifo_row_loader
    import fifo_row_loader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 8,
    parameter int ROWS  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS-1:0] in_data,
    output logic signed [BITS-1:0] row_d [DEPTH-1:0],
    output logic [ROWS-1:0]        fifo_wr,
    output logic                   fifo_en,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            stall_cnt
);

    localparam int            RW         = $clog2(ROWS);
    localparam int            DW         = $clog2(2 * DEPTH);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(stream_len(DEPTH) - 1);

    loader_state_t state, state_nxt;
    logic [RW-1:0] row_cnt;
    logic [DW-1:0] drain_cnt;
    logic          start_acc;
    logic          accept;
    logic          row_full;

    assign start_acc = (state == IDLE) && start;
    assign accept    = (state == FILL) && in_valid;

    row_assembler #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept),
        .clear    (start_acc),
        .data     (in_data),
        .row_d    (row_d),
        .row_full (row_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (row_full) state_nxt = LOAD;
            LOAD:    state_nxt = (row_cnt == ROW_LAST) ? STREAM : FILL;
            STREAM:  if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            row_cnt <= '0;
        else if (start_acc)
            row_cnt <= '0;
        else if (state == LOAD)
            row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
    end

    // Drain counter idles at zero so every STREAM starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drain_cnt <= '0;
        else if (state != STREAM)
            drain_cnt <= '0;
        else
            drain_cnt <= drain_cnt + 1'b1;
    end

    always_comb begin
        fifo_wr = '0;
        if (state == LOAD)
            fifo_wr[row_cnt] = 1'b1;
    end

    assign in_ready = (state == FILL);
    assign fifo_en  = (state == STREAM);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

`ifdef FIFO_ROW_LOADER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (start_acc)
            stall_q <= '0;
        else if ((state == FILL) && !in_valid && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_row_loader.sv
// Scoreboard bench for fifo_row_loader with a behavioural model of the FIFO bank.
module tb_fifo_row_loader;

    localparam int DEPTH = 8;
    localparam int BITS  = 8;
    localparam int ROWS  = 8;
    localparam int SLEN  = 2 * DEPTH - 1;
    localparam int W     = DEPTH * BITS;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic signed [BITS-1:0] in_data = '0;
    logic signed [BITS-1:0] row_d [DEPTH-1:0];
    logic [ROWS-1:0]        fifo_wr;
    logic                   fifo_en;
    logic                   busy;
    logic                   done;
    logic [15:0]            stall_cnt;

    fifo_row_loader #(.DEPTH(DEPTH), .BITS(BITS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .row_d     (row_d),
        .fifo_wr   (fifo_wr),
        .fifo_en   (fifo_en),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int         row;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] loaded [ROWS];
    logic [W-1:0] fq [ROWS];
    logic [W-1:0] rd_pk;
    int           t_wr [ROWS];
    int           t_en_first = 0;
    int           t_done = 0;
    int           en_run = 0;
    int           done_cnt = 0;

    always_comb begin
        rd_pk = '0;
        for (int i = 0; i < DEPTH; i++) rd_pk[i*BITS +: BITS] = row_d[i];
    end

    // FIFO bank model: load on wr, shift toward element 0 on en.
    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (fifo_wr[r]) fq[r] <= rd_pk;
            else if (fifo_en) fq[r] <= fq[r] >> BITS;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_wr != '0 || fifo_en)
                chk("wr_en_excl", 128'((fifo_wr != '0) && fifo_en), 128'd0);
            if (fifo_wr != '0) begin
                if (sbq.size() == 0) begin
                    chk("wr_unexpected", 128'(fifo_wr), 128'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("wr_onehot", 128'(fifo_wr), 128'(1) << e.row);
                    chk("row_d", 128'(rd_pk), 128'(e.data));
                    loaded[e.row] = e.data;
                    t_wr[e.row] = cyc;
                end
            end
            if (fifo_en) begin
                if (en_run == 0) t_en_first = cyc;
                for (int r = 0; r < ROWS; r++) begin
                    logic [BITS-1:0] ev;
                    ev = (en_run < DEPTH) ? loaded[r][en_run*BITS +: BITS] : '0;
                    chk($sformatf("fifo_out_r%0d_k%0d", r, en_run), 128'(fq[r][BITS-1:0]), 128'(ev));
                end
                en_run++;
            end else if (en_run != 0) begin
                chk("drain_len", 128'(en_run), 128'(SLEN));
                en_run = 0;
            end
            if (done) begin
                done_cnt++;
                t_done = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin step(); n++; end
        if (!in_ready) chk("ready_timeout", 128'(in_ready), 128'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 500) begin step(); n++; end
        chk("done_seen", 128'(done), 128'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: r*16+c; mode 1: -128 at col 0, -1 at last col; mode 2: random.
    task automatic load_matrix(input int mode, input bit gaps, input int abort_row);
        for (int r = 0; r < ROWS; r++) begin
            exp_t e;
            e.row = r;
            for (int c = 0; c < DEPTH; c++) begin
                logic [BITS-1:0] v;
                case (mode)
                    0:       v = BITS'(r * 16 + c);
                    1:       v = (c == 0) ? 8'h80 : (c == DEPTH - 1) ? 8'hFF : BITS'($urandom_range(0, 255));
                    default: v = BITS'($urandom_range(0, 255));
                endcase
                e.data[c*BITS +: BITS] = v;
            end
            sbq.push_back(e);
            for (int c = 0; c < DEPTH; c++) begin
                if (r == abort_row && c == 3) begin
                    in_valid = 1'b0;
                    return;
                end
                if (gaps) begin
                    wait_ready();
                    in_valid = 1'b0;
                    step();
                end
                in_valid = 1'b1;
                in_data  = e.data[c*BITS +: BITS];
                wait_ready();
                step();
            end
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_outs"}, 128'({in_ready, fifo_wr, fifo_en, busy, done, stall_cnt}), 128'd0);
        chk({tag, "_row_d"}, 128'(rd_pk), 128'd0);
    endtask

    initial begin
        int t0;
        int done0;

        step();
        step();
        chk_idle_zero("rst");
        rst_n = 1'b1;
        step();

        // Back-to-back beats: exact latency of every LOAD, the drain and done.
        in_valid = 1'b1;
        in_data  = '0;
        t0 = cyc;
        pulse_start();
        load_matrix(0, 1'b0, -1);
        in_valid = 1'b0;
        wait_done();
        step();
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("t_wr_r%0d", r), 128'(t_wr[r] - t0), 128'(9 * (r + 1)));
        chk("t_en_first", 128'(t_en_first - t0), 128'(ROWS * (DEPTH + 1) + 1));
        chk("t_done", 128'(t_done - t0), 128'(ROWS * (DEPTH + 1) + SLEN + 1));
        chk("stall_nogap", 128'(stall_cnt), 128'd0);
        chk("sbq_empty_a", 128'(sbq.size()), 128'd0);

        // One idle FILL cycle in front of every beat.
        pulse_start();
        load_matrix(2, 1'b1, -1);
        in_valid = 1'b0;
        wait_done();
        step();
`ifdef FIFO_ROW_LOADER_STALL_CNT_EN
        chk("stall_gap", 128'(stall_cnt), 128'(ROWS * DEPTH));
`else
        chk("stall_gap", 128'(stall_cnt), 128'd0);
`endif

        // Extreme negative values stay bit-exact.
        pulse_start();
        load_matrix(1, 1'b0, -1);
        in_valid = 1'b0;
        wait_done();
        step();
        chk("neg_col0", {120'd0, row_d[0]}, 128'h80);
        chk("neg_collast", {120'd0, row_d[DEPTH-1]}, 128'hFF);

        // Stray start pulses in FILL, STREAM and DONE.
        done0 = done_cnt;
        pulse_start();
        fork
            load_matrix(2, 1'b0, -1);
            begin
                step();
                step();
                pulse_start();
            end
        join
        in_valid = 1'b0;
        begin
            int n = 0;
            while (!fifo_en && n < 100) begin step(); n++; end
            chk("en_seen", 128'(fifo_en), 128'd1);
        end
        step();
        pulse_start();
        wait_done();
        pulse_start();
        step();
        step();
        chk("ign_busy", 128'(busy), 128'd0);
        chk("ign_done_cnt", 128'(done_cnt - done0), 128'd1);
        chk("sbq_empty_b", 128'(sbq.size()), 128'd0);

        // Asynchronous reset after 3 beats of row 2, then a clean reload.
        pulse_start();
        load_matrix(2, 1'b0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("midrst");
        sbq.delete();
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        load_matrix(2, 1'b0, -1);
        in_valid = 1'b0;
        wait_done();
        step();
        chk("sbq_empty_c", 128'(sbq.size()), 128'd0);
        chk("done_total", 128'(done_cnt), 128'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
